// File: rtl/mprj_io_pad_bfm.sv
// mprj_io_pad_bfm -- parametrised pad driver/monitor for the cocotb top.
//
// Drives NUM_PADS tri-state pads from config registers and watches the
// resolved pad levels. Every masked level change bumps a saturating per-pad
// toggle counter and pushes a {pad snapshot, timestamp} entry into a
// first-word-fall-through event FIFO that the Python side pops.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   pad_in            resolved pad levels (asynchronous to clock)
//   pad_out, pad_oe   drive value / enable (top: pad = oe ? out : 'z)
//   cfg_we/sel/wdata  config write: 0 pad_out, 1 pad_oe, 2 mask, 3 clear
//   evt_*             event FIFO head, ready/valid pop, occupancy, overflow
//   cnt_sel/value     combinational toggle-counter read port
//
// Build option: define GLITCH_FILTER_EN to put a FILTER_CYCLES stability
// filter between the synchroniser and the change detector.

// Per-pad lane: synchroniser, optional glitch filter, edge detect, counter.
module mprj_io_pad_lane #(
    parameter int CNT_WIDTH     = 16
`ifdef GLITCH_FILTER_EN
   ,parameter int FILTER_CYCLES = 3
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pad_in,
    input  logic                 mask,
    input  logic                 clr,
    output logic                 level,
    output logic                 change,
    output logic [CNT_WIDTH-1:0] count
);
    logic s1, s2, prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pad_in;
            s2   <= s1;
            // prev follows the level even while masked, so unmasking a pad
            // that moved earlier cannot fabricate an edge.
            prev <= level;
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILTER_CYCLES + 1);

    logic [FC_W-1:0] stab;
    logic            filt;

    // stab counts consecutive cycles s2 has disagreed with the filtered
    // level; the level flips on the FILTER_CYCLES-th such cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt <= 1'b0;
            stab <= '0;
        end else if (s2 != filt) begin
            if (stab == FC_W'(FILTER_CYCLES - 1)) begin
                filt <= s2;
                stab <= '0;
            end else begin
                stab <= stab + 1'b1;
            end
        end else begin
            stab <= '0;
        end
    end

    assign level = filt;
`else
    assign level = s2;
`endif

    assign change = (level ^ prev) & mask;

    // Clear wins over a same-cycle increment; counting stops at all-ones.
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (change && !(&count))
            count <= count + 1'b1;
    end
endmodule

module mprj_io_pad_bfm #(
    parameter int NUM_PADS      = 38,
    parameter int FIFO_DEPTH    = 16,
    parameter int TS_WIDTH      = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PADS-1:0]               pad_in,
    output logic [NUM_PADS-1:0]               pad_out,
    output logic [NUM_PADS-1:0]               pad_oe,
    input  logic                              cfg_we,
    input  logic [1:0]                        cfg_sel,
    input  logic [NUM_PADS-1:0]               cfg_wdata,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [NUM_PADS-1:0]               evt_pads,
    output logic [TS_WIDTH-1:0]               evt_time,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_level,
    output logic                              evt_overflow,
    input  logic [$clog2(NUM_PADS)-1:0]       cnt_sel,
    output logic [CNT_WIDTH-1:0]              cnt_value
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int SEL_W = $clog2(NUM_PADS);

    if (FILTER_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("mprj_io_pad_bfm: invalid FILTER_CYCLES or FIFO_DEPTH");
    end

    typedef struct packed {
        logic [NUM_PADS-1:0] pads;
        logic [TS_WIDTH-1:0] ts;
    } evt_t;

    logic [NUM_PADS-1:0]                mask;
    logic [NUM_PADS-1:0]                clr;
    logic [NUM_PADS-1:0]                lvl;
    logic [NUM_PADS-1:0]                change;
    logic [NUM_PADS-1:0][CNT_WIDTH-1:0] cnts;
    logic [TS_WIDTH-1:0]                ts;
    logic                               clr_ovf;

    // ---------------- config registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pad_out <= '0;
            pad_oe  <= '0;
            mask    <= '0;
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    pad_out <= cfg_wdata;
                2'd1:    pad_oe  <= cfg_wdata;
                2'd2:    mask    <= cfg_wdata;
                default: ;
            endcase
        end
    end

    assign clr_ovf = cfg_we && (cfg_sel == 2'd3);
    assign clr     = clr_ovf ? cfg_wdata : '0;

    // ---------------- per-pad lanes ----------------
    for (genvar g = 0; g < NUM_PADS; g++) begin : g_lane
        mprj_io_pad_lane #(
            .CNT_WIDTH     (CNT_WIDTH)
`ifdef GLITCH_FILTER_EN
           ,.FILTER_CYCLES (FILTER_CYCLES)
`endif
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .pad_in (pad_in[g]),
            .mask   (mask[g]),
            .clr    (clr[g]),
            .level  (lvl[g]),
            .change (change[g]),
            .count  (cnts[g])
        );
    end

    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < NUM_PADS; i++)
            if (cnt_sel == SEL_W'(i)) cnt_value = cnts[i];
    end

    // ---------------- free-running timestamp ----------------
    always_ff @(posedge clock) begin
        if (reset) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    // ---------------- event FIFO ----------------
    evt_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop, full, empty, accept;

    assign empty  = (evt_level == '0);
    assign full   = (evt_level == LVL_W'(FIFO_DEPTH));
    assign pop    = !empty && evt_ready;
    assign push   = |change;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign accept = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= '{pads: lvl, ts: ts};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_level    <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   evt_level <= evt_level + 1'b1;
                2'b01:   evt_level <= evt_level - 1'b1;
                default: ;
            endcase
            // A drop on the clearing edge is still reported.
            if (push && !accept)
                evt_overflow <= 1'b1;
            else if (clr_ovf)
                evt_overflow <= 1'b0;
        end
    end

    assign evt_valid = !empty;
    assign evt_pads  = empty ? '0 : mem[rd_ptr].pads;
    assign evt_time  = empty ? '0 : mem[rd_ptr].ts;
endmodule

// File: tb/tb_mprj_io_pad_bfm.sv
// Directed bench for mprj_io_pad_bfm: pads looped back through the
// tri-state resolution, expected events queued when stimulus is driven and
// compared as the FIFO head is popped.
module tb_mprj_io_pad_bfm;
    localparam int NP  = 38;
    localparam int FD  = 16;
    localparam int TSW = 4;
    localparam int CW  = 4;
    localparam int FC  = 3;
`ifdef GLITCH_FILTER_EN
    localparam int F = FC;
`else
    localparam int F = 0;
`endif

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [NP-1:0]             pad_in, pad_out, pad_oe;
    logic                      cfg_we = 1'b0;
    logic [1:0]                cfg_sel = '0;
    logic [NP-1:0]             cfg_wdata = '0;
    logic                      evt_valid;
    logic                      evt_ready = 1'b0;
    logic [NP-1:0]             evt_pads;
    logic [TSW-1:0]            evt_time;
    logic [$clog2(FD+1)-1:0]   evt_level;
    logic                      evt_overflow;
    logic [$clog2(NP)-1:0]     cnt_sel = '0;
    logic [CW-1:0]             cnt_value;
    logic [NP-1:0]             ext = '0;

    typedef struct packed {
        logic [NP-1:0]  pads;
        logic [TSW-1:0] t;
    } exp_t;

    exp_t           q[$];
    logic [NP-1:0]  out_m = '0;
    logic [TSW-1:0] ts_m;
    int             passed = 0;
    int             total  = 0;

    assign pad_in = (pad_oe & pad_out) | (~pad_oe & ext);

    mprj_io_pad_bfm #(
        .NUM_PADS(NP), .FIFO_DEPTH(FD), .TS_WIDTH(TSW),
        .CNT_WIDTH(CW), .FILTER_CYCLES(FC)
    ) dut (
        .clock(clock), .reset(reset), .pad_in(pad_in),
        .pad_out(pad_out), .pad_oe(pad_oe),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_pads(evt_pads), .evt_time(evt_time),
        .evt_level(evt_level), .evt_overflow(evt_overflow),
        .cnt_sel(cnt_sel), .cnt_value(cnt_value)
    );

    always #5 clock = ~clock;

    // Reference timestamp: 0 on the reset edge, +1 per edge afterwards.
    always @(posedge clock) ts_m <= reset ? '0 : ts_m + 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [NP-1:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cnt_chk(input string tag, input int idx, input int exp);
        cnt_sel = 6'(idx);
        #1;
        check(tag, 64'(cnt_value), 64'(exp));
    endtask

    // Called just after the edge on which the pad level changed.
    function automatic exp_t mk_exp(input logic [NP-1:0] p);
        exp_t e;
        e.pads = p;
        e.t    = TSW'(ts_m + 2 + F);
        return e;
    endfunction

    task automatic drain(input string tag);
        exp_t e;
        int   n;
        repeat (3 + F) tick();
        check({tag, "_level"}, 64'(evt_level), 64'(q.size()));
        n = q.size();
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 20 && !evt_valid; w++) tick();
            check({tag, "_valid"}, 64'(evt_valid), 64'(1'b1));
            e = q.pop_front();
            check({tag, "_pads"}, 64'(evt_pads), 64'(e.pads));
            check({tag, "_time"}, 64'(evt_time), 64'(e.t));
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        check({tag, "_empty"}, 64'(evt_valid), 64'(1'b0));
        check({tag, "_empty_pads"}, 64'(evt_pads), 64'(0));
        check({tag, "_empty_time"}, 64'(evt_time), 64'(0));
    endtask

    task automatic toggle3();
        out_m = out_m ^ NP'(8);
        cfg_write(2'd0, out_m);
    endtask

    initial begin
        exp_t e;

        // ---- reset ----
        repeat (3) tick();
        reset = 1'b0;
        check("rst_oe", 64'(pad_oe), 64'(0));
        check("rst_out", 64'(pad_out), 64'(0));
        check("rst_valid", 64'(evt_valid), 64'(0));
        check("rst_level", 64'(evt_level), 64'(0));
        check("rst_ovf", 64'(evt_overflow), 64'(0));
        check("rst_pads", 64'(evt_pads), 64'(0));
        check("rst_time", 64'(evt_time), 64'(0));
        cnt_chk("rst_cnt5", 5, 0);

        // ---- loopback: pad 5 rises from a pad_out write ----
        cfg_write(2'd1, '1);
        cfg_write(2'd2, '1);
        out_m = NP'(32);
        cfg_write(2'd0, out_m);
        q.push_back(mk_exp(out_m));
        check("loop_out", 64'(pad_out), 64'(out_m));
        drain("loop");
        cnt_chk("loop_cnt5", 5, 1);

        // ---- mask: unmasked toggles are invisible, unmasking is clean ----
        cfg_write(2'd2, '0);
        for (int i = 0; i < 10; i++) toggle3();
        repeat (6 + F) tick();
        check("mask_level0", 64'(evt_level), 64'(0));
        cnt_chk("mask_cnt3_0", 3, 0);
        cfg_write(2'd2, NP'(8));
        repeat (4 + F) tick();
        check("mask_nospur", 64'(evt_level), 64'(0));
        toggle3();
        q.push_back(mk_exp(out_m));
        drain("mask");
        cnt_chk("mask_cnt3_1", 3, 1);

        // ---- overflow: 17 events into a 16-deep FIFO ----
        for (int i = 0; i < 17; i++) begin
            toggle3();
            if (i < 16) q.push_back(mk_exp(out_m));
            repeat (F) tick();
        end
        repeat (3 + F) tick();
        check("ovf_level", 64'(evt_level), 64'(16));
        check("ovf_flag", 64'(evt_overflow), 64'(1));
        cnt_chk("ovf_cnt3_sat", 3, 15);

        // pop on the same edge as a push into a full FIFO
        toggle3();
        e = mk_exp(out_m);
        repeat (2 + F) tick();
        evt_ready = 1'b1;
        check("pp_head_pads", 64'(evt_pads), 64'(q[0].pads));
        check("pp_head_time", 64'(evt_time), 64'(q[0].t));
        tick();
        evt_ready = 1'b0;
        void'(q.pop_front());
        q.push_back(e);
        check("pp_level", 64'(evt_level), 64'(16));
        check("pp_ovf_sticky", 64'(evt_overflow), 64'(1));
        cfg_write(2'd3, '0);
        check("ovf_cleared", 64'(evt_overflow), 64'(0));
        cnt_chk("ovf_cnt3_kept", 3, 15);
        drain("ovf");

        // ---- clear lands on the same edge as an increment ----
        toggle3();
        q.push_back(mk_exp(out_m));
        repeat (2 + F) tick();
        cfg_write(2'd3, NP'(8));
        cnt_chk("clr_cnt3", 3, 0);
        cnt_chk("clr_cnt5_kept", 5, 1);
        cnt_chk("cnt_sel_oor", 40, 0);
        drain("clr");

        // ---- timestamp wrap: first event time 14, later ones wrap ----
        for (int i = 0; i < 16 && TSW'(ts_m + 3 + F) != 4'd14; i++) tick();
        for (int i = 0; i < 4; i++) begin
            toggle3();
            q.push_back(mk_exp(out_m));
            repeat (F) tick();
        end
        drain("wrap");
        cnt_chk("wrap_cnt3", 3, 4);

        // ---- reset on the edge a push would happen ----
        toggle3();
        repeat (2 + F) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_m = '0;
        q.delete();
        repeat (6 + F) tick();
        check("mrst_valid", 64'(evt_valid), 64'(0));
        check("mrst_level", 64'(evt_level), 64'(0));
        check("mrst_oe", 64'(pad_oe), 64'(0));
        check("mrst_out", 64'(pad_out), 64'(0));
        check("mrst_time", 64'(evt_time), 64'(0));
        cnt_chk("mrst_cnt3", 3, 0);
        cnt_chk("mrst_cnt5", 5, 0);

`ifdef GLITCH_FILTER_EN
        // ---- glitch filter on an externally driven pad ----
        cfg_write(2'd2, '1);
        ext[7] = 1'b1;
        repeat (2) tick();
        ext[7] = 1'b0;
        repeat (10) tick();
        check("filt_pulse_level", 64'(evt_level), 64'(0));
        cnt_chk("filt_pulse_cnt", 7, 0);
        ext[7] = 1'b1;
        q.push_back(mk_exp(ext));
        drain("filt");
        cnt_chk("filt_cnt", 7, 1);
        ext[7] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("filt_rst_valid", 64'(evt_valid), 64'(0));
        check("filt_rst_level", 64'(evt_level), 64'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
